// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   AXI4-Lite read master that prefetches 32-bit instructions ahead of the core.
//   Each fetched word is stored with its PC in a small FIFO. The FIFO head is
//   presented to decode as a valid/ready stream. A redirect (taken branch/jump)
//   clears the FIFO and restarts fetch at the target. Any AXI beat that is still
//   in flight when the redirect arrives is drained and discarded.
//
// Parameters
//   XLEN        data/address width
//   FIFO_DEPTH  prefetch entries (power of two, >= 2)
//   RESET_PC    first fetch address after reset
//
// Ports
//   i_Clock, i_Reset                     clock, asynchronous active-high reset
//   i_Redirect_Valid, i_Redirect_PC      fetch restart request from the core
//   o_Instruction, o_Instruction_PC      FIFO head (NOP / 0 when empty)
//   o_Fetch_Error                        head was fetched with RRESP != OKAY
//   o_Instruction_Valid, i_Instruction_Ready   core-side stream handshake
//   o_Araddr, o_Arvalid, i_Arready       AXI read address channel
//   i_Rdata, i_Rresp, i_Rvalid, o_Rready AXI read data channel
//
// Build option
//   IFU_MISALIGN_TRAP_EN: when defined, a redirect to a PC with [1:0] != 0
//   issues no read. Instead, a single {PC, NOP, error} entry is queued, and fetch
//   stalls until the next redirect. When undefined, the redirect target is
//   aligned down to a word boundary.

module instruction_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Redirect_Valid,
  input  logic [XLEN-1:0] i_Redirect_PC,
  output logic [31:0]     o_Instruction,
  output logic [XLEN-1:0] o_Instruction_PC,
  output logic            o_Fetch_Error,
  output logic            o_Instruction_Valid,
  input  logic            i_Instruction_Ready,
  output logic [XLEN-1:0] o_Araddr,
  output logic            o_Arvalid,
  input  logic            i_Arready,
  input  logic [31:0]     i_Rdata,
  input  logic [1:0]      i_Rresp,
  input  logic            i_Rvalid,
  output logic            o_Rready
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FLUSH} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            err;
  } entry_t;

  state_t          state, state_d;
  logic [XLEN-1:0] fetch_pc, fetch_pc_d;
  logic [XLEN-1:0] araddr_q;
  logic [XLEN-1:0] redir_pc;
  logic            redir_pend, redir_pend_d;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head, push_entry;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_d;
  logic            empty, push, pop, flush;
  logic            space_after_push;
  logic            fetch_blocked, trap_push;

  // ---------------------------------------------------------------------------
  // Redirect target handling
  // ---------------------------------------------------------------------------
`ifdef IFU_MISALIGN_TRAP_EN
  logic trap_pend, trap_hold, misalign;

  assign misalign = |i_Redirect_PC[1:0];
  assign redir_pc = i_Redirect_PC;

  // The trap entry is queued from IDLE only. By the time IDLE is reached, any
  // beat that was in flight at the redirect has been drained, and the FIFO is
  // known to be empty.
  assign trap_push     = (state == IDLE) && trap_pend && !i_Redirect_Valid;
  assign fetch_blocked = trap_pend || trap_hold;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      trap_pend <= 1'b0;
      trap_hold <= 1'b0;
    end else if (i_Redirect_Valid) begin
      trap_pend <= misalign;
      trap_hold <= 1'b0;
    end else if (trap_push) begin
      trap_pend <= 1'b0;
      trap_hold <= 1'b1;
    end
  end
`else
  logic unused_redir_lsbs;

  assign unused_redir_lsbs = ^i_Redirect_PC[1:0];
  assign redir_pc          = {i_Redirect_PC[XLEN-1:2], 2'b00};
  assign trap_push         = 1'b0;
  assign fetch_blocked     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  assign empty = (count == '0);
  assign flush = i_Redirect_Valid;
  // A redirect clears the FIFO, so a pop in the same cycle has no effect.
  assign pop   = i_Instruction_Ready && !empty && !flush;
  assign head  = mem[rd_ptr];

  // This value is consulted only in DATA, where count < FIFO_DEPTH always holds.
  // The +1 therefore never overflows CW bits.
  assign space_after_push = (count + CW'(1) - CW'(pop)) < DEPTH_C;

  assign count_d = flush ? '0 : (count + CW'(push) - CW'(pop));

  // ---------------------------------------------------------------------------
  // Fetch FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state;
    fetch_pc_d   = fetch_pc;
    redir_pend_d = redir_pend;
    push         = 1'b0;
    push_entry   = '{pc: fetch_pc, instr: i_Rdata, err: (i_Rresp != 2'b00)};

    case (state)
      IDLE: begin
        if (!i_Redirect_Valid && !fetch_blocked && (count < DEPTH_C))
          state_d = ADDR;
      end
      ADDR: begin
        // AR stays stable until it is accepted. A redirect seen meanwhile is
        // remembered, so that the resulting beat is dropped.
        if (i_Redirect_Valid)
          redir_pend_d = 1'b1;
        if (i_Arready) begin
          state_d      = (redir_pend || i_Redirect_Valid) ? FLUSH : DATA;
          redir_pend_d = 1'b0;
        end
      end
      DATA: begin
        if (i_Redirect_Valid) begin
          // If the beat lands in the redirect cycle, it is consumed and discarded
          // here. Nothing is left to drain in that case.
          state_d = i_Rvalid ? IDLE : FLUSH;
        end else if (i_Rvalid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc + XLEN'(4);
          state_d    = space_after_push ? ADDR : IDLE;
        end
      end
      FLUSH: begin
        if (i_Rvalid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_Redirect_Valid)
      fetch_pc_d = redir_pc;

    if (trap_push) begin
      push       = 1'b1;
      push_entry = '{pc: fetch_pc, instr: NOP, err: 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      araddr_q   <= RESET_PC;
      redir_pend <= 1'b0;
    end else begin
      state      <= state_d;
      fetch_pc   <= fetch_pc_d;
      redir_pend <= redir_pend_d;
      // The address is latched on entry to ADDR and then held until it is accepted.
      if ((state != ADDR) && (state_d == ADDR))
        araddr_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset. Entries are only observed through count.
  always_ff @(posedge i_Clock) begin
    if (push)
      mem[wr_ptr] <= push_entry;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_Instruction_Valid = !empty;
  assign o_Instruction       = empty ? NOP : head.instr;
  assign o_Instruction_PC    = empty ? '0  : head.pc;
  assign o_Fetch_Error       = !empty && head.err;

  assign o_Arvalid = (state == ADDR);
  assign o_Araddr  = araddr_q;
  assign o_Rready  = (state == DATA) || (state == FLUSH);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        i_Reset;
  logic        i_Redirect_Valid;
  logic [31:0] i_Redirect_PC;
  logic [31:0] o_Instruction;
  logic [31:0] o_Instruction_PC;
  logic        o_Fetch_Error;
  logic        o_Instruction_Valid;
  logic        i_Instruction_Ready;
  logic [31:0] o_Araddr;
  logic        o_Arvalid;
  logic        i_Arready;
  logic [31:0] i_Rdata;
  logic [1:0]  i_Rresp;
  logic        i_Rvalid;
  logic        o_Rready;

  instruction_fetch_unit #(.XLEN(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_Clock             (clk),
    .i_Reset             (i_Reset),
    .i_Redirect_Valid    (i_Redirect_Valid),
    .i_Redirect_PC       (i_Redirect_PC),
    .o_Instruction       (o_Instruction),
    .o_Instruction_PC    (o_Instruction_PC),
    .o_Fetch_Error       (o_Fetch_Error),
    .o_Instruction_Valid (o_Instruction_Valid),
    .i_Instruction_Ready (i_Instruction_Ready),
    .o_Araddr            (o_Araddr),
    .o_Arvalid           (o_Arvalid),
    .i_Arready           (i_Arready),
    .i_Rdata             (i_Rdata),
    .i_Rresp             (i_Rresp),
    .i_Rvalid            (i_Rvalid),
    .o_Rready            (o_Rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
  endtask

  // Memory slave: word[n] = n; the R beat comes r_delay cycles after AR.
  int          r_delay = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFC;
  logic [31:0] ar_log[$];
  bit          s_pend = 0;
  int          s_cnt = 0;
  logic [31:0] s_addr = 0;

  initial begin
    i_Rvalid = 1'b0;
    i_Rdata  = '0;
    i_Rresp  = 2'b00;
    forever begin
      @(posedge clk);
      if (i_Reset) begin
        s_pend = 0;
      end else begin
        if (i_Rvalid && o_Rready) s_pend = 0;
        if (o_Arvalid && i_Arready) begin
          s_pend = 1;
          s_addr = o_Araddr;
          s_cnt  = r_delay;
          ar_log.push_back(o_Araddr);
        end else if (s_pend && s_cnt > 0) begin
          s_cnt--;
        end
      end
      #1;
      i_Rvalid = s_pend && (s_cnt == 0);
      i_Rdata  = s_addr >> 2;
      i_Rresp  = (s_addr == err_addr) ? 2'b10 : 2'b00;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input bit arready, input bit ready);
    i_Reset             = 1'b1;
    i_Redirect_Valid    = 1'b0;
    i_Redirect_PC       = '0;
    i_Arready           = arready;
    i_Instruction_Ready = ready;
    repeat (2) @(posedge clk);
    ar_log.delete();
    @(negedge clk);
    i_Reset = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    i_Redirect_Valid = 1'b1;
    i_Redirect_PC    = pc;
    @(negedge clk);
    i_Redirect_Valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 0;
    for (int c = 0; c < max; c++) begin
      if (o_Instruction_Valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit          ready;
    bit          valid;
    logic [31:0] instr;
    logic [31:0] pc;
    bit          arvalid;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    int n, stale, n0;

    // Per-cycle trace after reset release. The slave is always ready and answers
    // in 1 cycle. Row 3 holds ready low, so that rows 4/5 exercise a push and a pop
    // in the same cycle.
    vecs[0] = '{1'b1, 1'b0, NOP,   32'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, NOP,   32'h0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, NOP,   32'h0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'd0, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'd0, 32'h0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'd1, 32'h4, 1'b1};
    vecs[6] = '{1'b1, 1'b0, NOP,   32'h0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'd2, 32'h8, 1'b1};

    // ---- reset state + stream trace
    do_reset(1'b1, 1'b1);
    chk("rst_rready", o_Rready, 0);
    chk("rst_araddr", o_Araddr, 0);
    chk("rst_err", o_Fetch_Error, 0);
    for (int i = 0; i < 8; i++) begin
      i_Instruction_Ready = vecs[i].ready;
      chk($sformatf("t1_valid[%0d]", i), o_Instruction_Valid, vecs[i].valid);
      chk($sformatf("t1_instr[%0d]", i), o_Instruction, vecs[i].instr);
      chk($sformatf("t1_pc[%0d]", i), o_Instruction_PC, vecs[i].pc);
      chk($sformatf("t1_arvalid[%0d]", i), o_Arvalid, vecs[i].arvalid);
      @(negedge clk);
    end

    // ---- full FIFO stall, then resume with no PC gaps
    do_reset(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("full_ar_count", ar_log.size(), 4);
    chk("full_arvalid", o_Arvalid, 0);
    chk("full_head_pc", o_Instruction_PC, 0);
    i_Instruction_Ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      if (c < 2) chk($sformatf("resume_arvalid[%0d]", c), o_Arvalid, 0);
      if (c == 2) begin
        chk("resume_arvalid[2]", o_Arvalid, 1);
        chk("resume_araddr", o_Araddr, 32'h10);
      end
      if (o_Instruction_Valid) begin
        chk($sformatf("resume_pc[%0d]", n), o_Instruction_PC, n * 4);
        chk($sformatf("resume_instr[%0d]", n), o_Instruction, n);
        n++;
      end
      @(negedge clk);
    end
    chk("resume_count", n, 10);

    // ---- redirect in DATA with a slow R beat
    r_delay = 3;
    do_reset(1'b1, 1'b1);
    for (int c = 0; c < 20 && !o_Rready; c++) @(negedge clk);
    chk("t3_in_data", o_Rready, 1);
    pulse_redirect(32'h100);
    stale = 0;
    ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      if (o_Instruction_Valid) begin
        if (o_Instruction_PC < 32'h100) stale++;
        else begin
          ok = 1;
          chk("t3_first_pc", o_Instruction_PC, 32'h100);
          chk("t3_first_instr", o_Instruction, 32'h40);
        end
      end
      @(negedge clk);
    end
    chk("t3_got_entry", ok, 1);
    chk("t3_stale", stale, 0);
    r_delay = 0;

    // ---- redirect while AR is stalled by the slave
    do_reset(1'b0, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_arvalid[%0d]", k), o_Arvalid, 1);
      chk($sformatf("t4_araddr[%0d]", k), o_Araddr, 0);
      i_Redirect_Valid = (k == 0);
      i_Redirect_PC    = 32'h200;
      @(negedge clk);
    end
    i_Redirect_Valid = 1'b0;
    i_Arready        = 1'b1;
    wait_valid(40, ok);
    chk("t4_got_entry", ok, 1);
    chk("t4_pc", o_Instruction_PC, 32'h200);
    chk("t4_instr", o_Instruction, 32'h80);
    chk("t4_ar_count_ge2", ar_log.size() >= 2, 1);
    if (ar_log.size() >= 2) chk("t4_second_ar", ar_log[1], 32'h200);

    // ---- error response at PC 0x8
    err_addr = 32'h8;
    do_reset(1'b1, 1'b1);
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (o_Instruction_Valid) begin
        chk($sformatf("t5_pc[%0d]", n), o_Instruction_PC, n * 4);
        chk($sformatf("t5_instr[%0d]", n), o_Instruction, n);
        chk($sformatf("t5_err[%0d]", n), o_Fetch_Error, (n == 2));
        n++;
      end
      @(negedge clk);
    end
    chk("t5_count", n, 4);
    err_addr = 32'hFFFF_FFFC;

    // ---- asynchronous reset in DATA
    r_delay = 3;
    for (int c = 0; c < 20 && !o_Rready; c++) @(negedge clk);
    chk("t5_in_data", o_Rready, 1);
    #3 i_Reset = 1'b1;
    #1;
    chk("arst_arvalid", o_Arvalid, 0);
    chk("arst_rready", o_Rready, 0);
    chk("arst_valid", o_Instruction_Valid, 0);
    chk("arst_instr", o_Instruction, NOP);
    chk("arst_pc", o_Instruction_PC, 0);
    chk("arst_araddr", o_Araddr, 0);
    r_delay = 0;
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    chk("arst_restart_arvalid", o_Arvalid, 1);
    chk("arst_restart_araddr", o_Araddr, 0);
    wait_valid(20, ok);
    chk("arst_restart_pc", o_Instruction_PC, 0);

    // ---- misaligned redirect target
`ifdef IFU_MISALIGN_TRAP_EN
    do_reset(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    pulse_redirect(32'h102);
    repeat (12) @(negedge clk);
    chk("trap_valid", o_Instruction_Valid, 1);
    chk("trap_pc", o_Instruction_PC, 32'h102);
    chk("trap_instr", o_Instruction, NOP);
    chk("trap_err", o_Fetch_Error, 1);
    n0 = ar_log.size();
    repeat (10) @(negedge clk);
    chk("trap_no_ar", ar_log.size(), n0);
    chk("trap_arvalid", o_Arvalid, 0);
    i_Instruction_Ready = 1'b1;
    @(negedge clk);
    chk("trap_single_entry", o_Instruction_Valid, 0);
    pulse_redirect(32'h200);
    wait_valid(40, ok);
    chk("trap_resume_pc", o_Instruction_PC, 32'h200);
    chk("trap_resume_err", o_Fetch_Error, 0);
`else
    do_reset(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    pulse_redirect(32'h102);
    wait_valid(40, ok);
    chk("align_got_entry", ok, 1);
    chk("align_pc", o_Instruction_PC, 32'h100);
    chk("align_instr", o_Instruction, 32'h40);
    chk("align_err", o_Fetch_Error, 0);
    n0 = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
